// File: rtl/div_unit.sv
// Purpose : multi-cycle restoring integer divider for DIV/DIVU in EX, one quotient bit per clock.
// Latency : ready_o rises 32 cycles after start_i is accepted (1 cycle for a zero divisor).
// Backpr. : EX holds start_i until it sees ready_o; result_o stays valid until start_i drops.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend, opdata2_i divisor (sampled only when a request is accepted)
//   start_i       request, held until ready_o
//   annul_i       cancel an in-flight division (pipeline flush)
//   result_o      {remainder, quotient}
//   ready_o       result_o valid
//
// Build option: define DIV_SIGNED_EN to honour signed_div_i (magnitude conversion and
// sign correction). Without it every operation is unsigned.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  localparam logic [5:0] LAST_CNT = 6'(DATA_W - 1);

  state_t              state;
  logic [5:0]          cnt;
  // Upper DATA_W+1 bits: partial remainder. Lower DATA_W bits: dividend bits
  // still to be consumed, progressively replaced by quotient bits.
  logic [2*DATA_W:0]   work;
  logic [DATA_W-1:0]   divisor_r;

  logic [DATA_W-1:0]   dividend_mag;
  logic [DATA_W-1:0]   divisor_mag;
  logic [2*DATA_W:0]   shifted;
  logic [DATA_W:0]     trial;
  logic [2*DATA_W:0]   work_next;
  logic [DATA_W-1:0]   quot_raw;
  logic [DATA_W-1:0]   rem_raw;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;

  // The remainder is always below the divisor, so the top bit of the working
  // register is zero whenever it is stored; the shift simply discards it.
  logic unused_work_top;
  assign unused_work_top = work[2*DATA_W];

  // One restoring step. The partial remainder before the subtract is below
  // 2*divisor, so a non-negative difference fits in DATA_W bits and bit DATA_W
  // of the trial result is a reliable borrow flag.
  always_comb begin
    shifted   = {work[2*DATA_W-1:0], 1'b0};
    trial     = shifted[2*DATA_W:DATA_W] - {1'b0, divisor_r};
    work_next = shifted;
    if (!trial[DATA_W]) begin
      work_next = {trial, shifted[DATA_W-1:1], 1'b1};
    end
  end

  assign quot_raw = work_next[DATA_W-1:0];
  assign rem_raw  = work_next[2*DATA_W-1:DATA_W];

`ifdef DIV_SIGNED_EN
  logic dividend_neg;
  logic divisor_neg;
  logic dividend_neg_r;
  logic quot_neg_r;

  assign dividend_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign divisor_neg  = signed_div_i & opdata2_i[DATA_W-1];
  assign dividend_mag = dividend_neg ? (DATA_W'(0) - opdata1_i) : opdata1_i;
  assign divisor_mag  = divisor_neg  ? (DATA_W'(0) - opdata2_i) : opdata2_i;
  // Remainder takes the dividend's sign; the most negative dividend over -1
  // wraps back to itself, which is the architected result.
  assign quot_fix     = quot_neg_r     ? (DATA_W'(0) - quot_raw) : quot_raw;
  assign rem_fix      = dividend_neg_r ? (DATA_W'(0) - rem_raw)  : rem_raw;
`else
  logic unused_signed;
  assign unused_signed = signed_div_i;
  assign dividend_mag  = opdata1_i;
  assign divisor_mag   = opdata2_i;
  assign quot_fix      = quot_raw;
  assign rem_fix       = rem_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FREE;
      cnt       <= '0;
      work      <= '0;
      divisor_r <= '0;
      result_o  <= '0;
      ready_o   <= 1'b0;
`ifdef DIV_SIGNED_EN
      dividend_neg_r <= 1'b0;
      quot_neg_r     <= 1'b0;
`endif
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state     <= ON;
              cnt       <= '0;
              work      <= {{(DATA_W+1){1'b0}}, dividend_mag};
              divisor_r <= divisor_mag;
`ifdef DIV_SIGNED_EN
              dividend_neg_r <= dividend_neg;
              quot_neg_r     <= dividend_neg ^ divisor_neg;
`endif
            end
          end
        end

        BYZERO: begin
          state    <= END;
          result_o <= '0;
          ready_o  <= 1'b1;
        end

        ON: begin
          if (annul_i) begin
            state   <= FREE;
            ready_o <= 1'b0;
          end else begin
            work <= work_next;
            cnt  <= cnt + 6'd1;
            if (cnt == LAST_CNT) begin
              state    <= END;
              result_o <= {rem_fix, quot_fix};
              ready_o  <= 1'b1;
            end
          end
        end

        END: begin
          // Annul is ignored here: the result is complete and EX owns the handshake.
          if (!start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end

        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the EX stage for DIV/DIVU. EX is the initiator: it presents operands and raises a start request, holding the pipeline stalled until this block answers with ready and a 64-bit {remainder, quotient} result. Restoring algorithm, one quotient bit per cycle; annul support for pipeline flush.

## Interface

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = signed division (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  division request from EX; held high until ready_o seen.
- annul_i  in  1  cancel in-flight division (flush).
- result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  result_o valid.

## Operation

- States: FREE, BYZERO, ON, END. 2-bit state reg, 6-bit cnt, 2*DATA_W+1 working reg, latched sign flags.
- Reset: state=FREE, cnt=0, ready_o=0, result_o=0. Reset has priority over everything, including mid-division.
- FREE: ready_o=0, result_o=0.
  - start_i=1, annul_i=0, opdata2_i=0 -> BYZERO.
  - start_i=1, annul_i=0, opdata2_i!=0 -> ON; cnt<=0; load magnitudes (two's complement of negative operands when signed); latch dividend sign and quotient sign (dividend sign XOR divisor sign).
  - start_i=0 or annul_i=1 -> stay.
- BYZERO: next edge -> END, result_o<=0, ready_o<=1.
- ON:
  - annul_i=1 -> FREE, ready_o<=0, result discarded.
  - Otherwise one iteration per edge: shift working reg left 1; trial subtract divisor from upper part; if non-negative, keep difference and set LSB=1, else LSB=0. cnt<=cnt+1.
  - Iteration with cnt==DATA_W-1 -> END; same edge registers result_o with sign correction and ready_o<=1.
- Sign correction (signed only): quotient negated if quotient sign latched 1; remainder negated if dividend sign latched 1. Remainder sign follows dividend.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (no trap, no special case).
- END: ready_o=1, result_o held stable.
  - start_i=0 -> FREE, ready_o<=0, result_o<=0.
  - start_i=1 -> stay, including if annul_i=1. EX must drop start_i after capturing.
- Operands sampled only on the FREE->ON/BYZERO edge; later input changes are ignored.

## Timing

- Edge 0 = edge where start_i is sampled in FREE.
- Nonzero divisor: iterations on edges 1..32; ready_o high after edge 32 (32 cycles after edge 0).
- Zero divisor: ready_o high after edge 1.
- ready_o and result_o are registered; no combinational input-to-output path.
- ready_o falls on the edge after start_i is sampled low in END; a new start_i is accepted no earlier than the following edge (FREE).
- Annul in ON takes effect at that edge; start_i high with annul_i=0 on the next edge begins a fresh division.

## Configuration

- DIV_SIGNED_EN defined: signed_div_i honoured; magnitude conversion and sign correction logic present.
- Not defined: signed_div_i ignored, all operations unsigned, no negation logic; DIV behaves as DIVU.

## Test plan

- Unsigned 100 / 7, start held -> ready_o rises exactly 32 cycles after edge 0; result_o = {0x00000002, 0x0000000E}.
- Signed (DIV_SIGNED_EN) -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; without macro 0xFFFFFFF9 / 2 -> quotient 0x7FFFFFFC, remainder 1.
- Divide by zero 5 / 0 -> ready_o high after edge 1, result_o = 0.
- Annul at cycle 10 of ON -> ready_o never rises, state FREE; immediate new start 9 / 3 -> quotient 3, remainder 0 after 32 cycles.
- Handshake: start_i held 5 cycles after ready_o -> result_o stable, ready_o stays high; drop start_i -> ready_o=0, result_o=0 next edge.
- rst asserted at cycle 15 of ON -> state FREE, ready_o=0, result_o=0 after that edge; next division correct.
